// File: rtl/operand_read_stage_pkg.sv
// Shared widths and the per-channel held-register type for the operand read stage.
package operand_read_stage_pkg;

  localparam int OPR_NUM_CH = 3;
  localparam int OPR_NUM_WB = 3;
  localparam int OPR_XLEN   = 32;
  localparam int OPR_PREG_W = 7;
  localparam int OPR_UOP_W  = 64;
  localparam int OPR_CNT_W  = 16;

  // Contents of one channel's output pipeline register.
  typedef struct packed {
    logic                valid;
    logic [OPR_XLEN-1:0] ps1_data;
    logic [OPR_XLEN-1:0] ps2_data;
    logic [OPR_UOP_W-1:0] uop;
  } opr_ch_t;

endpackage

// File: rtl/operand_read_stage_if.sv
// Issue, PRF read, writeback-bypass and FU handshake bundle of the operand read stage.
interface operand_read_stage_if
  import operand_read_stage_pkg::*;
#(
  parameter int NUM_CH = OPR_NUM_CH,
  parameter int NUM_WB = OPR_NUM_WB,
  parameter int XLEN   = OPR_XLEN,
  parameter int PREG_W = OPR_PREG_W,
  parameter int UOP_W  = OPR_UOP_W,
  parameter int CNT_W  = OPR_CNT_W
);

  logic                              flush;
  logic [NUM_CH-1:0]                 issue_valid;
  logic [NUM_CH-1:0]                 issue_ready;
  logic [NUM_CH-1:0][PREG_W-1:0]     issue_ps1;
  logic [NUM_CH-1:0][PREG_W-1:0]     issue_ps2;
  logic [NUM_CH-1:0][UOP_W-1:0]      issue_uop;
  logic [NUM_CH-1:0]                 rd_en1;
  logic [NUM_CH-1:0]                 rd_en2;
  logic [NUM_CH-1:0][PREG_W-1:0]     rd_addr1;
  logic [NUM_CH-1:0][PREG_W-1:0]     rd_addr2;
  logic [NUM_CH-1:0][XLEN-1:0]       rd_data1;
  logic [NUM_CH-1:0][XLEN-1:0]       rd_data2;
  logic [NUM_WB-1:0]                 wb_valid;
  logic [NUM_WB-1:0][PREG_W-1:0]     wb_preg;
  logic [NUM_WB-1:0][XLEN-1:0]       wb_data;
  logic [NUM_CH-1:0]                 fu_valid;
  logic [NUM_CH-1:0]                 fu_ready;
  logic [NUM_CH-1:0][XLEN-1:0]       fu_ps1_data;
  logic [NUM_CH-1:0][XLEN-1:0]       fu_ps2_data;
  logic [NUM_CH-1:0][UOP_W-1:0]      fu_uop;
  logic [NUM_CH-1:0][CNT_W-1:0]      stall_cnt;

  // Environment side: reservation stations, PRF, writeback network and FUs.
  modport master (
    output flush, issue_valid, issue_ps1, issue_ps2, issue_uop,
    output rd_data1, rd_data2, wb_valid, wb_preg, wb_data, fu_ready,
    input  issue_ready, rd_en1, rd_en2, rd_addr1, rd_addr2,
    input  fu_valid, fu_ps1_data, fu_ps2_data, fu_uop, stall_cnt
  );

  // Stage side.
  modport slave (
    input  flush, issue_valid, issue_ps1, issue_ps2, issue_uop,
    input  rd_data1, rd_data2, wb_valid, wb_preg, wb_data, fu_ready,
    output issue_ready, rd_en1, rd_en2, rd_addr1, rd_addr2,
    output fu_valid, fu_ps1_data, fu_ps2_data, fu_uop, stall_cnt
  );

endinterface

// File: rtl/operand_read_stage_opr_bypass_mux.sv
// Selects one source operand: zero register, lowest-index writeback hit, else PRF data.
module opr_bypass_mux
  import operand_read_stage_pkg::*;
#(
  parameter int NUM_WB = OPR_NUM_WB,
  parameter int XLEN   = OPR_XLEN,
  parameter int PREG_W = OPR_PREG_W
) (
  input  logic [PREG_W-1:0]              ps,
  input  logic [XLEN-1:0]                rd_data,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0]  wb_preg,
  input  logic [NUM_WB-1:0][XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]                operand
);

  logic hit;

  // Walk writeback ports upward so the first match wins; p0 overrides everything.
  always_comb begin
    operand = rd_data;
    hit     = 1'b0;
    for (int unsigned w = 0; w < NUM_WB; w++) begin
      if (!hit && wb_valid[w] && (wb_preg[w] == ps)) begin
        operand = wb_data[w];
        hit     = 1'b1;
      end
    end
    if (ps == '0) operand = '0;
  end

endmodule

// File: rtl/operand_read_stage.sv
// Registered register-read stage: PRF read, writeback bypass, per-channel
// valid/ready output register with flush and saturating stall counters.
module operand_read_stage
  import operand_read_stage_pkg::*;
#(
  parameter int NUM_CH = OPR_NUM_CH,
  parameter int NUM_WB = OPR_NUM_WB,
  parameter int XLEN   = OPR_XLEN,
  parameter int PREG_W = OPR_PREG_W,
  parameter int UOP_W  = OPR_UOP_W,
  parameter int CNT_W  = OPR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_read_stage_if.slave  bus
);

  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] accept;
  logic [XLEN-1:0]   op1    [NUM_CH];
  logic [XLEN-1:0]   op2    [NUM_CH];
  opr_ch_t           held_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];

  assign bus.issue_ready = ready;
  assign bus.rd_en1      = accept;
  assign bus.rd_en2      = accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Ready ignores issue_valid so the RS can use it without a combinational loop.
    assign ready[c]        = !bus.flush && (!held_q[c].valid || bus.fu_ready[c]);
    assign accept[c]       = bus.issue_valid[c] && ready[c];
    assign bus.rd_addr1[c] = accept[c] ? bus.issue_ps1[c] : '0;
    assign bus.rd_addr2[c] = accept[c] ? bus.issue_ps2[c] : '0;

    opr_bypass_mux #(.NUM_WB(NUM_WB), .XLEN(XLEN), .PREG_W(PREG_W)) u_mux1 (
      .ps       (bus.issue_ps1[c]),
      .rd_data  (bus.rd_data1[c]),
      .wb_valid (bus.wb_valid),
      .wb_preg  (bus.wb_preg),
      .wb_data  (bus.wb_data),
      .operand  (op1[c])
    );

    opr_bypass_mux #(.NUM_WB(NUM_WB), .XLEN(XLEN), .PREG_W(PREG_W)) u_mux2 (
      .ps       (bus.issue_ps2[c]),
      .rd_data  (bus.rd_data2[c]),
      .wb_valid (bus.wb_valid),
      .wb_preg  (bus.wb_preg),
      .wb_data  (bus.wb_data),
      .operand  (op2[c])
    );

    // Output register: flush kills, accept captures (also on back-to-back), drain clears.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        held_q[c] <= '0;
      end else if (bus.flush) begin
        held_q[c].valid <= 1'b0;
      end else if (accept[c]) begin
        held_q[c] <= '{valid: 1'b1, ps1_data: op1[c], ps2_data: op2[c], uop: bus.issue_uop[c]};
      end else if (held_q[c].valid && bus.fu_ready[c]) begin
        held_q[c].valid <= 1'b0;
      end
    end

    // Count cycles a valid result waits on the FU; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[c] <= '0;
      end else if (held_q[c].valid && !bus.fu_ready[c] && !bus.flush && (cnt_q[c] != '1)) begin
        cnt_q[c] <= cnt_q[c] + 1'b1;
      end
    end

    assign bus.fu_valid[c]    = held_q[c].valid;
    assign bus.fu_ps1_data[c] = held_q[c].ps1_data;
    assign bus.fu_ps2_data[c] = held_q[c].ps2_data;
    assign bus.fu_uop[c]      = held_q[c].uop;
    assign bus.stall_cnt[c]   = cnt_q[c];
  end

endmodule

// File: tb/tb_operand_read_stage.sv
// Self-checking bench for operand_read_stage: directed cases plus random traffic,
// with a per-channel scoreboard of expected FU payloads.
module tb_operand_read_stage;
  import operand_read_stage_pkg::*;

  localparam int NCH = 3;
  localparam int NWB = 3;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] u;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] prf [128];
  exp_t        sb [NCH][$];
  logic [NCH-1:0] mdl_valid = '0;
  logic [15:0]    mdl_cnt [NCH] = '{default: '0};

  operand_read_stage_if #(
    .NUM_CH(NCH), .NUM_WB(NWB), .XLEN(32), .PREG_W(7), .UOP_W(64), .CNT_W(16)
  ) bus ();

  operand_read_stage #(
    .NUM_CH(NCH), .NUM_WB(NWB), .XLEN(32), .PREG_W(7), .UOP_W(64), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // PRF model: combinational read on the stage's addresses.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      bus.rd_data1[c] = prf[bus.rd_addr1[c]];
      bus.rd_data2[c] = prf[bus.rd_addr2[c]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_operand(input logic [6:0] ps);
    if (ps == 7'd0) return 32'd0;
    for (int w = 0; w < NWB; w++)
      if (bus.wb_valid[w] && bus.wb_preg[w] == ps) return bus.wb_data[w];
    return prf[ps];
  endfunction

  // Scoreboard/monitor: checks outputs mid-cycle, then advances the reference model.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("rst_fu_valid%0d", c), bus.fu_valid[c], 0);
        check($sformatf("rst_ps1_%0d", c), bus.fu_ps1_data[c], 0);
        check($sformatf("rst_ps2_%0d", c), bus.fu_ps2_data[c], 0);
        check($sformatf("rst_uop%0d", c), bus.fu_uop[c], 0);
        check($sformatf("rst_stall%0d", c), bus.stall_cnt[c], 0);
        mdl_valid[c] = 1'b0;
        mdl_cnt[c]   = '0;
        sb[c].delete();
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic er, acc;
        exp_t e;
        check($sformatf("fu_valid%0d", c), bus.fu_valid[c], mdl_valid[c]);
        er  = !bus.flush && (!mdl_valid[c] || bus.fu_ready[c]);
        acc = bus.issue_valid[c] && er;
        check($sformatf("issue_ready%0d", c), bus.issue_ready[c], er);
        check($sformatf("rd_en1_%0d", c), bus.rd_en1[c], acc);
        check($sformatf("rd_en2_%0d", c), bus.rd_en2[c], acc);
        check($sformatf("rd_addr1_%0d", c), bus.rd_addr1[c], acc ? bus.issue_ps1[c] : 7'd0);
        check($sformatf("rd_addr2_%0d", c), bus.rd_addr2[c], acc ? bus.issue_ps2[c] : 7'd0);
        if (mdl_valid[c]) begin
          if (sb[c].size() == 0) check($sformatf("sb_size%0d", c), sb[c].size(), 1);
          else begin
            check($sformatf("fu_ps1_%0d", c), bus.fu_ps1_data[c], sb[c][0].a);
            check($sformatf("fu_ps2_%0d", c), bus.fu_ps2_data[c], sb[c][0].b);
            check($sformatf("fu_uop%0d", c), bus.fu_uop[c], sb[c][0].u);
          end
        end
        check($sformatf("stall%0d", c), bus.stall_cnt[c], mdl_cnt[c]);
        if (mdl_valid[c] && !bus.fu_ready[c] && !bus.flush && mdl_cnt[c] != 16'hFFFF)
          mdl_cnt[c] = mdl_cnt[c] + 16'd1;
        if (bus.flush) begin
          if (mdl_valid[c] && sb[c].size() > 0) void'(sb[c].pop_front());
          mdl_valid[c] = 1'b0;
        end else if (acc) begin
          if (mdl_valid[c] && sb[c].size() > 0) void'(sb[c].pop_front());
          e.a = ref_operand(bus.issue_ps1[c]);
          e.b = ref_operand(bus.issue_ps2[c]);
          e.u = bus.issue_uop[c];
          sb[c].push_back(e);
          mdl_valid[c] = 1'b1;
        end else if (mdl_valid[c] && bus.fu_ready[c]) begin
          if (sb[c].size() > 0) void'(sb[c].pop_front());
          mdl_valid[c] = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = '0;
    bus.wb_valid    = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic issue(input int c, input logic [6:0] p1, input logic [6:0] p2, input logic [63:0] u);
    bus.issue_valid[c] = 1'b1;
    bus.issue_ps1[c]   = p1;
    bus.issue_ps2[c]   = p2;
    bus.issue_uop[c]   = u;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) prf[i] = $urandom;
    prf[0]  = 32'h5;
    prf[5]  = 32'h11;
    prf[9]  = 32'h22;
    prf[12] = 32'hDEAD;
    bus.flush = 1'b0;
    bus.issue_valid = '0;
    bus.issue_ps1 = '0;
    bus.issue_ps2 = '0;
    bus.issue_uop = '0;
    bus.wb_valid = '0;
    bus.wb_preg = '0;
    bus.wb_data = '0;
    bus.fu_ready = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Basic read on channel 0.
    bus.fu_ready = '1;
    issue(0, 7'd5, 7'd9, 64'h1000);
    #1;
    check("basic_rd_en", bus.rd_en1[0], 1);
    check("basic_addr1", bus.rd_addr1[0], 5);
    check("basic_addr2", bus.rd_addr2[0], 9);
    cyc();
    idle();
    check("basic_valid", bus.fu_valid[0], 1);
    check("basic_ps1", bus.fu_ps1_data[0], 32'h11);
    check("basic_ps2", bus.fu_ps2_data[0], 32'h22);
    cyc();

    // Bypass beats stale PRF; lowest matching writeback port wins.
    issue(1, 7'd12, 7'd3, 64'h2000);
    bus.wb_valid = 3'b100;
    bus.wb_preg[2] = 7'd12;
    bus.wb_data[2] = 32'hBEEF;
    cyc();
    check("bypass_wb2", bus.fu_ps1_data[1], 32'hBEEF);
    bus.wb_valid = 3'b101;
    bus.wb_preg[0] = 7'd12;
    bus.wb_data[0] = 32'hAAAA;
    cyc();
    check("bypass_prio", bus.fu_ps1_data[1], 32'hAAAA);
    idle();

    // Zero register ignores PRF and writeback to p0.
    issue(0, 7'd0, 7'd5, 64'h3000);
    bus.wb_valid = 3'b010;
    bus.wb_preg[1] = 7'd0;
    bus.wb_data[1] = 32'h7;
    cyc();
    idle();
    check("zero_ps1", bus.fu_ps1_data[0], 0);
    check("zero_ps2", bus.fu_ps2_data[0], 32'h11);
    cyc();

    // Backpressure on channel 2 with a second instruction waiting.
    bus.fu_ready[2] = 1'b0;
    issue(2, 7'd20, 7'd21, 64'hA);
    cyc();
    issue(2, 7'd22, 7'd23, 64'hB);
    #1;
    check("bp_not_ready", bus.issue_ready[2], 0);
    repeat (3) cyc();
    check("bp_stall3", bus.stall_cnt[2], 3);
    check("bp_hold_ps1", bus.fu_ps1_data[2], prf[20]);
    check("bp_hold_uop", bus.fu_uop[2], 64'hA);
    bus.fu_ready[2] = 1'b1;
    #1;
    check("bp_ready", bus.issue_ready[2], 1);
    cyc();
    idle();
    check("bp_next_valid", bus.fu_valid[2], 1);
    check("bp_next_uop", bus.fu_uop[2], 64'hB);
    check("bp_next_ps2", bus.fu_ps2_data[2], prf[23]);
    cyc();

    // Flush with held work and new issues in the same cycle.
    bus.fu_ready = '0;
    for (int c = 0; c < NCH; c++) issue(c, 7'(30 + c), 7'(40 + c), 64'(c));
    cyc();
    bus.flush = 1'b1;
    for (int c = 0; c < NCH; c++) issue(c, 7'(50 + c), 7'(60 + c), 64'(c + 8));
    #1;
    check("flush_rd_en1", bus.rd_en1, 0);
    check("flush_rd_en2", bus.rd_en2, 0);
    check("flush_ready", bus.issue_ready, 0);
    cyc();
    idle();
    check("flush_valid", bus.fu_valid, 0);
    cyc();

    // Asynchronous reset while channel 0 is stalled.
    issue(0, 7'd7, 7'd8, 64'hC);
    cyc();
    idle();
    cyc();
    check("pre_rst_stall", bus.stall_cnt[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.fu_valid, 0);
    check("arst_stall", bus.stall_cnt, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Random traffic with small register indices to provoke bypass hits.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        bus.issue_valid[c] = ($urandom_range(0, 3) != 0);
        bus.issue_ps1[c]   = 7'($urandom_range(0, 15));
        bus.issue_ps2[c]   = 7'($urandom_range(0, 15));
        bus.issue_uop[c]   = {$urandom, $urandom};
        bus.fu_ready[c]    = ($urandom_range(0, 2) != 0);
      end
      for (int w = 0; w < NWB; w++) begin
        bus.wb_valid[w] = ($urandom_range(0, 1) != 0);
        bus.wb_preg[w]  = 7'($urandom_range(0, 15));
        bus.wb_data[w]  = $urandom;
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      cyc();
    end
    idle();
    bus.fu_ready = '1;
    repeat (3) cyc();
    for (int c = 0; c < NCH; c++) check($sformatf("drain%0d", c), sb[c].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
